// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg
//   Shared timing definitions for the CPU control unit: sequencer state
//   encoding, default ring widths, the interrupt dispatch length and the
//   index of the last T-step within an M-cycle.
package cpu_seq_pkg;

    localparam int unsigned STEP_W_DEF      = 4;
    localparam int unsigned COUNT_W_DEF     = 8;
    localparam int unsigned INT_MCYCLES_DEF = 5;

    // T-step on which an M-cycle ends and boundary decisions are taken.
    localparam int unsigned STEP_LAST = STEP_W_DEF - 1;

    typedef enum logic [1:0] {
        EXECUTE      = 2'd0,
        HALTED       = 2'd1,
        INT_DISPATCH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/onehot_ring.sv
// onehot_ring
//   One-hot rotating register. Bit 0 is set out of reset.
//   Ports:
//     i_Clk     - clock
//     i_Reset   - asynchronous active-high reset to bit 0
//     i_Hold    - freeze the ring this clock (highest priority)
//     i_Reload  - return to bit 0
//     i_Advance - rotate left by one (MSB wraps to bit 0)
//     o_Ring    - current one-hot value
module onehot_ring #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Hold,
    input  logic             i_Reload,
    input  logic             i_Advance,
    output logic [WIDTH-1:0] o_Ring
);

    logic [WIDTH-1:0] ring_q;
    logic [WIDTH-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (i_Hold) begin
            ring_d = ring_q;
        end else if (i_Reload) begin
            ring_d = WIDTH'(1);
        end else if (i_Advance) begin
            ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            ring_q <= WIDTH'(1);
        end else begin
            ring_q <= ring_d;
        end
    end

    assign o_Ring = ring_q;

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
//   Owns CPU timing state: the one-hot T-step ring, the one-hot M-cycle ring
//   and the EXECUTE / HALTED / INT_DISPATCH state machine that sequences
//   opcode load, HALT entry and wake, and interrupt dispatch.
//   Ports:
//     i_Clk, i_Reset  - clock, asynchronous active-high reset
//     i_Stall         - memory wait, freezes all sequencer state
//     i_IR_Fetch      - current M-cycle is the instruction's last
//     i_Halt          - HALT opcode executing
//     i_Int_Pending   - an enabled interrupt is flagged
//     i_IME           - interrupt master enable
//     o_Cycle_Step    - one-hot T-step
//     o_Cycle_Count   - one-hot M-cycle index
//     o_IR_Load       - opcode register load pulse
//     o_Int_Active    - interrupt dispatch in progress
//     o_Int_Ack       - dispatch complete pulse
//     o_Halted        - CPU halted
//     o_Seq_Error     - M-cycle count overflowed without IR_Fetch
module cycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned STEP_W      = STEP_W_DEF,
    parameter int unsigned COUNT_W     = COUNT_W_DEF,
    parameter int unsigned INT_MCYCLES = INT_MCYCLES_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Stall,
    input  logic               i_IR_Fetch,
    input  logic               i_Halt,
    input  logic               i_Int_Pending,
    input  logic               i_IME,
    output logic [STEP_W-1:0]  o_Cycle_Step,
    output logic [COUNT_W-1:0] o_Cycle_Count,
    output logic               o_IR_Load,
    output logic               o_Int_Active,
    output logic               o_Int_Ack,
    output logic               o_Halted,
    output logic               o_Seq_Error
);

    seq_state_e state_q, state_d;
    // Set when a HALT is left without dispatch: the first M-cycle after
    // wake is always an opcode fetch, whatever the decoder still presents.
    logic       wake_fetch_q, wake_fetch_d;

    logic [STEP_W-1:0]  step;
    logic [COUNT_W-1:0] count;

    logic step_adv, step_reload;
    logic count_adv, count_reload;
    logic m_end;
    logic ir_load, int_ack, seq_error;

    onehot_ring #(.WIDTH(STEP_W)) u_step_ring (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Hold    (i_Stall),
        .i_Reload  (step_reload),
        .i_Advance (step_adv),
        .o_Ring    (step)
    );

    onehot_ring #(.WIDTH(COUNT_W)) u_count_ring (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Hold    (i_Stall),
        .i_Reload  (count_reload),
        .i_Advance (count_adv),
        .o_Ring    (count)
    );

    assign m_end = step[STEP_W-1] & ~i_Stall;

    always_comb begin
        state_d      = state_q;
        wake_fetch_d = wake_fetch_q;
        step_adv     = 1'b0;
        step_reload  = 1'b0;
        count_adv    = 1'b0;
        count_reload = 1'b0;
        ir_load      = 1'b0;
        int_ack      = 1'b0;
        seq_error    = 1'b0;

        case (state_q)
            EXECUTE: begin
                step_adv = ~i_Stall;
                if (m_end) begin
                    if (wake_fetch_q) begin
                        count_reload = 1'b1;
                        ir_load      = 1'b1;
                        wake_fetch_d = 1'b0;
                    end else if (i_IR_Fetch) begin
                        count_reload = 1'b1;
                        // Interrupt outranks HALT; neither loads an opcode.
                        if (i_Int_Pending && i_IME) begin
                            state_d = INT_DISPATCH;
                        end else if (i_Halt) begin
                            state_d = HALTED;
                        end else begin
                            ir_load = 1'b1;
                        end
                    end else if (count[COUNT_W-1]) begin
                        count_reload = 1'b1;
                        seq_error    = 1'b1;
                        ir_load      = 1'b1;
                    end else begin
                        count_adv = 1'b1;
                    end
                end
            end

            HALTED: begin
                step_reload = ~i_Stall;
                if (!i_Stall && i_Int_Pending) begin
                    if (i_IME) begin
                        state_d = INT_DISPATCH;
                    end else begin
                        state_d      = EXECUTE;
                        wake_fetch_d = 1'b1;
                    end
                end
            end

            INT_DISPATCH: begin
                step_adv = ~i_Stall;
                if (m_end) begin
                    if (count[INT_MCYCLES-1]) begin
                        int_ack      = 1'b1;
                        ir_load      = 1'b1;
                        count_reload = 1'b1;
                        state_d      = EXECUTE;
                    end else begin
                        count_adv = 1'b1;
                    end
                end
            end

            default: begin
                state_d      = EXECUTE;
                wake_fetch_d = 1'b0;
                step_reload  = 1'b1;
                count_reload = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= EXECUTE;
            wake_fetch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wake_fetch_q <= wake_fetch_d;
        end
    end

    assign o_Cycle_Step  = step;
    assign o_Cycle_Count = count;
    assign o_IR_Load     = ir_load;
    assign o_Int_Ack     = int_ack;
    assign o_Seq_Error   = seq_error;
    assign o_Int_Active  = (state_q == INT_DISPATCH);
    assign o_Halted      = (state_q == HALTED);

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Generates the one-hot T-step (`Cycle_Step`) and M-cycle (`Cycle_Count`) timing vectors that every instruction microcode block decodes. It closes each instruction on the OR'd `IR_Fetch` request from the active microcode block. It also sequences the instruction-boundary events: opcode load, HALT entry and wake, and the 5 M-cycle interrupt dispatch. It sits in the control unit between the opcode decoder and the microcode blocks, and is the only owner of CPU timing state.

## Interface
Parameters:
- `STEP_W`, default 4: T-steps per M-cycle; one-hot width.
- `COUNT_W`, default 8: maximum M-cycles per instruction; one-hot width.
- `INT_MCYCLES`, default 5: M-cycles in interrupt dispatch; must be ≤ `COUNT_W`.

Ports:
- `i_Clk`, input, 1: CPU clock; one T-step per rising edge.
- `i_Reset`, input, 1: asynchronous, active-high reset.
- `i_Stall`, input, 1: memory wait; freezes all sequencer state for that clock.
- `i_IR_Fetch`, input, 1: OR of all microcode `o_IR_Fetch`; the current M-cycle is the instruction's last.
- `i_Halt`, input, 1: decoded HALT opcode is executing.
- `i_Int_Pending`, input, 1: (IE & IF) != 0.
- `i_IME`, input, 1: interrupt master enable.
- `o_Cycle_Step`, output, `STEP_W`: one-hot T-step.
- `o_Cycle_Count`, output, `COUNT_W`: one-hot M-cycle index within the instruction or dispatch.
- `o_IR_Load`, output, 1: pulse; the opcode register latches the bus this clock.
- `o_Int_Active`, output, 1: dispatch in progress; the decoder selects the dispatch microcode.
- `o_Int_Ack`, output, 1: pulse; dispatch complete, clear the serviced IF bit and IME.
- `o_Halted`, output, 1: the CPU is in the HALT state.
- `o_Seq_Error`, output, 1: pulse; `Cycle_Count` overflowed without `IR_Fetch`.

## Operation
- The FSM has three states: `EXECUTE`, `HALTED` and `INT_DISPATCH`. Reset enters `EXECUTE` with the decoder holding NOP, so the first M-cycle is a fetch.
- Step ring:
  - Rotates 0001→0010→0100→1000→0001 each unstalled clock in `EXECUTE` and `INT_DISPATCH`.
  - Holds at 0001 in `HALTED`.
- Count ring:
  - Shifts left by one at step[3] (the M-cycle end) when unstalled.
  - Reloads to 0x01 at the M-cycle end when any boundary rule below fires.
- Boundary in `EXECUTE` (step[3] & `i_IR_Fetch` & ~`i_Stall`): count goes to 0x01. Priority order:
  1. `i_Int_Pending` & `i_IME` → `INT_DISPATCH`, with no `o_IR_Load`.
  2. Otherwise `i_Halt` → `HALTED`, with no `o_IR_Load`.
  3. Otherwise stay in `EXECUTE` and pulse `o_IR_Load`.
- `HALTED`: `o_Halted` = 1. Any `i_Int_Pending` wakes the CPU on the next clock:
  - If `i_IME` = 1 → `INT_DISPATCH`.
  - Otherwise → `EXECUTE` with `o_IR_Load` pulsed at the first step[3].
- `INT_DISPATCH`: `o_Int_Active` = 1 while count runs bit0..bit(`INT_MCYCLES`-1). At step[3] of the last M-cycle:
  - `o_Int_Ack` pulses.
  - The FSM returns to `EXECUTE` with count 0x01 and `o_IR_Load` pulsed.
  - `i_IR_Fetch`, `i_Halt` and new interrupts are ignored during dispatch.
- Overflow: at step[3] with count[`COUNT_W`-1] and no `i_IR_Fetch`, count reloads to 0x01, `o_Seq_Error` pulses and `o_IR_Load` pulses. The FSM stays in `EXECUTE`.

## Timing
- Reset values: step 0001, count 0x01, state `EXECUTE`. `o_IR_Load`, `o_Int_Active`, `o_Int_Ack`, `o_Halted` and `o_Seq_Error` are all 0.
- Reset is asynchronous and takes effect immediately, including mid-instruction and mid-dispatch. No partial state survives.
- Step and count are registered outputs.
- `o_IR_Load`, `o_Int_Ack` and `o_Seq_Error` are combinational decodes of registered state and inputs, valid in the step[3] clock only, and are suppressed when `i_Stall` = 1.
- A stall at step[3] defers the boundary decision. Inputs are re-sampled on the first unstalled step[3] clock.
- `i_Int_Pending` and `i_Halt` are sampled only at the boundary clock (`EXECUTE`) or every clock (`HALTED`).
- An instruction of N M-cycles occupies exactly 4N unstalled clocks. LD (a16),A = 16 clocks, with `IR_Fetch` in count[3].
- Halt wake latency: 1 clock from `i_Int_Pending` to leaving `HALTED`.

## Structure
- Shared package `cpu_seq_pkg`:
  - State enum: `EXECUTE`, `HALTED`, `INT_DISPATCH`.
  - `STEP_W`, `COUNT_W`, `INT_MCYCLES` defaults.
  - The `STEP_LAST` index constant.
- Sub-module `onehot_ring`: parameterised width, with advance, reload-to-bit0 and hold inputs and an async reset to bit0. It is instantiated twice, once for step and once for count.
- The FSM and boundary priority logic live in `cycle_sequencer`.

## Test plan
- Reset release, NOP loop (`IR_Fetch` in count[0]) → step cycles 1,2,4,8; count stays 0x01; `o_IR_Load` pulses every 4th clock.
- 4 M-cycle instruction (`IR_Fetch` at count 0x08) → count 01,02,04,08,01; 16 clocks; one `o_IR_Load`. Insert a 3-clock `i_Stall` at step 0100 → 19 clocks total.
- At the boundary, `i_Int_Pending`=1, `i_IME`=1, `i_Halt`=1 together → `INT_DISPATCH` (interrupt beats halt); `o_Int_Active` for 20 clocks; `o_Int_Ack` at count 0x10 step 8; then `o_IR_Load`.
- HALT with `i_IME`=0; raise `i_Int_Pending` after 10 clocks → `o_Halted` 1→0 next clock; `EXECUTE` resumes with no `o_Int_Active`.
- No `IR_Fetch` for 8 M-cycles → at count 0x80 step 8, `o_Seq_Error`=1 and count returns to 0x01.
- Assert `i_Reset` at count 0x04 step 0010 of a dispatch → outputs return to reset values asynchronously; after release, step 0001 and count 0x01.
